norm_seq_ctrl: RTL and testbench

- Row sequencer that drives the stream-1 side of the softmax-style normalizer.
- Fetches one psum row (COL lanes) at a time from the core's psum SRAM and issues it to the normalizer.
- Collects the COL serial normalized beats and writes each to the output buffer at row*COL+lane.
- Runs entirely in clk; stream 2 is supplied by the other core through the normalizer's own CDC FIFO.

---
 rtl/norm_pkg.sv | 18 +
 rtl/norm_wr_addr_gen.sv | 53 +++++
 rtl/norm_seq_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_norm_seq_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/norm_pkg.sv
// Shared types and default sizes for the normalizer row sequencer.
package norm_pkg;

  localparam int NORM_COL     = 8;
  localparam int NORM_BW_PSUM = 16;
  localparam int NORM_W_OUT   = 16;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    ISSUE,
    DRAIN
  } state_e;

  typedef logic [NORM_COL-1:0][NORM_BW_PSUM-1:0] psum_row_t;

endpackage

// File: rtl/norm_wr_addr_gen.sv
// Row/beat counters for the output buffer; address is {row, beat}, so COL must be a power of two.
module norm_wr_addr_gen #(
  parameter int COL    = 8,
  parameter int ROW_AW = 6,
  parameter int OUT_AW = ROW_AW + $clog2(COL)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              beat_en_i,
  input  logic              row_inc_i,
  output logic [ROW_AW-1:0] row_o,
  output logic [OUT_AW-1:0] waddr_o,
  output logic              row_done_o
);

  localparam int BEAT_W = $clog2(COL);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(COL - 1);

  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [ROW_AW-1:0] row_q, row_d;

  assign row_done_o = beat_en_i && (beat_q == BEAT_LAST);
  assign row_o      = row_q;
  assign waddr_o    = {row_q, beat_q};

  always_comb begin
    beat_d = beat_q;
    row_d  = row_q;
    if (clr_i) begin
      beat_d = '0;
      row_d  = '0;
    end else begin
      if (beat_en_i) begin
        beat_d = (beat_q == BEAT_LAST) ? '0 : beat_q + 1'b1;
      end
      if (row_inc_i) begin
        row_d = row_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_q <= '0;
      row_q  <= '0;
    end else begin
      beat_q <= beat_d;
      row_q  <= row_d;
    end
  end

endmodule

// File: rtl/norm_seq_ctrl.sv
// Stream-1 row sequencer: fetches psum rows, issues them to the normalizer, writes normalized beats out.
// Optional watchdog enabled by defining NORM_SEQ_CTRL_WDOG_EN.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | psum SRAM read issued for current row
// LOAD  | SRAM data captured into norm_psum
// ISSUE | norm_s_valid held until first normalized beat
// DRAIN | collecting remaining beats of the row
module norm_seq_ctrl
  import norm_pkg::*;
#(
  parameter int BW_PSUM  = NORM_BW_PSUM,
  parameter int COL      = NORM_COL,
  parameter int W_OUT    = NORM_W_OUT,
  parameter int ROW_AW   = 6,
  parameter int OUT_AW   = ROW_AW + $clog2(COL),
  parameter int WDOG_CYC = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ROW_AW:0]        num_rows,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   mem_ren,
  output logic [ROW_AW-1:0]      mem_raddr,
  input  logic [COL*BW_PSUM-1:0] mem_rdata,
  output logic                   norm_s_valid,
  output logic [COL*BW_PSUM-1:0] norm_psum,
  input  logic                   norm_valid,
  input  logic [W_OUT-1:0]       norm_data,
  output logic                   out_wen,
  output logic [OUT_AW-1:0]      out_waddr,
  output logic [W_OUT-1:0]       out_wdata
);

  state_e                   state_q, state_d;
  logic [ROW_AW:0]          num_rows_q, num_rows_d;
  logic [COL*BW_PSUM-1:0]   psum_q, psum_d;
  logic                     done_q, done_d;
  logic                     wen_q;
  logic [OUT_AW-1:0]        waddr_q;
  logic [W_OUT-1:0]         wdata_q;

  logic                     active;
  logic                     beat_en;
  logic                     cnt_clr;
  logic                     row_inc;
  logic                     row_done;
  logic                     last_row;
  logic                     wdog_to;
  logic [ROW_AW-1:0]        row;
  logic [OUT_AW-1:0]        gen_waddr;

  assign active   = (state_q == ISSUE) || (state_q == DRAIN);
  assign beat_en  = active && norm_valid;
  assign last_row = ((ROW_AW+1)'(row) == (num_rows_q - (ROW_AW+1)'(1)));

  norm_wr_addr_gen #(
    .COL    (COL),
    .ROW_AW (ROW_AW),
    .OUT_AW (OUT_AW)
  ) u_wr_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (cnt_clr),
    .beat_en_i  (beat_en),
    .row_inc_i  (row_inc),
    .row_o      (row),
    .waddr_o    (gen_waddr),
    .row_done_o (row_done)
  );

  always_comb begin
    state_d    = state_q;
    num_rows_d = num_rows_q;
    psum_d     = psum_q;
    done_d     = 1'b0;
    cnt_clr    = 1'b0;
    row_inc    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (num_rows == '0) begin
            done_d = 1'b1;
          end else begin
            num_rows_d = num_rows;
            cnt_clr    = 1'b1;
            state_d    = FETCH;
          end
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        psum_d  = mem_rdata;
        state_d = ISSUE;
      end
      ISSUE: begin
        if (norm_valid) state_d = DRAIN;
      end
      DRAIN: begin
        if (row_done) begin
          if (last_row) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            row_inc = 1'b1;
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A timeout can only fire in a cycle with no beat, so it never races row_done.
    if (wdog_to) begin
      done_d  = 1'b1;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      num_rows_q <= '0;
      psum_q     <= '0;
      done_q     <= 1'b0;
      wen_q      <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      num_rows_q <= num_rows_d;
      psum_q     <= psum_d;
      done_q     <= done_d;
      wen_q      <= beat_en;
      if (beat_en) begin
        waddr_q <= gen_waddr;
        wdata_q <= norm_data;
      end
    end
  end

`ifdef NORM_SEQ_CTRL_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYC + 1);
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(WDOG_CYC - 1);

  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            err_q, err_d;

  // Down-counter reloads on every beat and whenever the row is not in flight.
  assign wdog_to = active && !norm_valid && (wdog_q == '0);

  always_comb begin
    wdog_d = WD_LOAD;
    if (active && !norm_valid) wdog_d = wdog_q - 1'b1;
    err_d = err_q;
    if ((state_q == IDLE) && start) err_d = 1'b0;
    else if (wdog_to)               err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_q <= WD_LOAD;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  // Watchdog not built: never fires, waits indefinitely for beats.
  assign wdog_to = (WDOG_CYC < 0);
  assign err     = 1'b0;
`endif

  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign mem_ren      = (state_q == FETCH);
  assign mem_raddr    = mem_ren ? row : '0;
  assign norm_s_valid = (state_q == ISSUE);
  assign norm_psum    = psum_q;
  assign out_wen      = wen_q;
  assign out_waddr    = waddr_q;
  assign out_wdata    = wdata_q;

endmodule

// File: tb/tb_norm_seq_ctrl.sv
// Self-checking bench for norm_seq_ctrl with SRAM and normalizer behavioural models.
module tb_norm_seq_ctrl;
  import norm_pkg::*;

  localparam int COL     = NORM_COL;
  localparam int BW      = NORM_BW_PSUM;
  localparam int W_OUT   = NORM_W_OUT;
  localparam int ROW_AW  = 6;
  localparam int OUT_AW  = ROW_AW + $clog2(COL);
  localparam int WDOG    = 64;

  logic                  clk;
  logic                  reset;
  logic                  start;
  logic [ROW_AW:0]       num_rows;
  logic                  busy, done, err;
  logic                  mem_ren;
  logic [ROW_AW-1:0]     mem_raddr;
  logic [COL*BW-1:0]     mem_rdata;
  logic                  norm_s_valid;
  logic [COL*BW-1:0]     norm_psum;
  logic                  norm_valid;
  logic [W_OUT-1:0]      norm_data;
  logic                  out_wen;
  logic [OUT_AW-1:0]     out_waddr;
  logic [W_OUT-1:0]      out_wdata;

  norm_seq_ctrl #(
    .BW_PSUM(BW), .COL(COL), .W_OUT(W_OUT), .ROW_AW(ROW_AW), .OUT_AW(OUT_AW), .WDOG_CYC(WDOG)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .num_rows(num_rows),
    .busy(busy), .done(done), .err(err),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .norm_s_valid(norm_s_valid), .norm_psum(norm_psum),
    .norm_valid(norm_valid), .norm_data(norm_data),
    .out_wen(out_wen), .out_waddr(out_waddr), .out_wdata(out_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  psum_row_t         mem_rows [64];
  logic [W_OUT-1:0]  got [1 << OUT_AW];
  int                wr_cnt, done_cnt, sv_rises;
  int                rd_q [$];
  logic              sv_prev = 1'b0;
  bit                rsp_mute, rsp_abort;

  function automatic logic [W_OUT-1:0] norm_fn(input logic [BW-1:0] p);
    return W_OUT'(p * 3 + 2);
  endfunction

  // SRAM: one-cycle read latency, garbage when not read.
  always @(posedge clk)
    mem_rdata <= mem_ren ? mem_rows[mem_raddr] : {COL{16'hDEAD}};

  // Normalizer: on seeing s_valid, after 0..3 cycles emit COL beats with optional 1-cycle gaps.
  initial begin
    psum_row_t lat_row;
    norm_valid = 1'b0;
    norm_data  = '0;
    forever begin
      @(posedge clk); #1;
      if (!rsp_mute && norm_s_valid === 1'b1) begin
        lat_row = norm_psum;
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        for (int b = 0; b < COL; b++) begin
          if (rsp_abort) break;
          norm_valid = 1'b1;
          norm_data  = norm_fn(lat_row[b]);
          @(posedge clk); #1;
          norm_valid = 1'b0;
          norm_data  = W_OUT'($urandom);
          if (b != COL - 1) repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
        end
        norm_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (out_wen === 1'b1) begin
      got[out_waddr] = out_wdata;
      wr_cnt++;
    end
    if (mem_ren === 1'b1) rd_q.push_back(int'(mem_raddr));
    if (done === 1'b1) done_cnt++;
    if (norm_s_valid === 1'b1 && sv_prev !== 1'b1) sv_rises++;
    sv_prev = norm_s_valid;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    wr_cnt = 0; done_cnt = 0; sv_rises = 0;
    rd_q.delete();
    for (int a = 0; a < (1 << OUT_AW); a++) got[a] = 'x;
  endtask

  task automatic fill_rows(input int n);
    for (int r = 0; r < n; r++)
      for (int l = 0; l < COL; l++) mem_rows[r][l] = BW'($urandom);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},  busy, 1'b0);
    check({tag, "_done"},  done, 1'b0);
    check({tag, "_ren"},   mem_ren, 1'b0);
    check({tag, "_raddr"}, mem_raddr, '0);
    check({tag, "_sval"},  norm_s_valid, 1'b0);
    check({tag, "_psum"},  norm_psum === '0, 1'b1);
    check({tag, "_wen"},   out_wen, 1'b0);
    check({tag, "_waddr"}, out_waddr, '0);
    check({tag, "_wdata"}, out_wdata, '0);
  endtask

  task automatic run_job(input string tag, input int n, input bit mid_start);
    int cyc;
    bit sent;
    clear_stats();
    start = 1'b1; num_rows = (ROW_AW+1)'(n);
    @(posedge clk); #1;
    start = 1'b0; num_rows = (ROW_AW+1)'($urandom);
    cyc = 0; sent = 0;
    while (done_cnt == 0 && cyc < 4000) begin
      if (mid_start && !sent && wr_cnt >= COL + 1) begin
        start = 1'b1; num_rows = 7'd5; sent = 1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    check({tag, "_finished"}, cyc < 4000, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_wr_cnt"}, wr_cnt, n * COL);
    check({tag, "_rd_cnt"}, rd_q.size(), n);
    check({tag, "_sval_cnt"}, sv_rises, n);
    for (int i = 0; i < rd_q.size() && i < n; i++)
      check($sformatf("%s_raddr%0d", tag, i), rd_q[i], i);
    for (int r = 0; r < n; r++)
      for (int l = 0; l < COL; l++)
        check($sformatf("%s_data%0d", tag, r * COL + l), got[r * COL + l], norm_fn(mem_rows[r][l]));
  endtask

  initial begin
    int cyc;
    int d0;
    reset = 1'b1; start = 1'b0; num_rows = '0;
    rsp_mute = 0; rsp_abort = 0;
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    check("reset_err", err, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int l = 0; l < COL; l++) mem_rows[0][l] = 16'd10;
    run_job("one_row", 1, 0);
    check("one_row_val32", got[COL-1], 16'd32);

    fill_rows(3);
    run_job("three_rows", 3, 0);

    clear_stats();
    start = 1'b1; num_rows = '0;
    @(posedge clk); #1;
    start = 1'b0;
    check("zero_done_hi", done, 1'b1);
    check("zero_busy", busy, 1'b0);
    @(posedge clk); #1;
    check("zero_done_lo", done, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    check("zero_ren", rd_q.size(), 0);
    check("zero_wen", wr_cnt, 0);
    check("zero_done_cnt", done_cnt, 1);

    fill_rows(3);
    run_job("restart_ignored", 3, 1);

    fill_rows(3);
    clear_stats();
    start = 1'b1; num_rows = 7'd3;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (wr_cnt < COL + 3 && cyc < 1000) begin @(posedge clk); #1; cyc++; end
    check("rst_reached_row1", cyc < 1000, 1'b1);
    d0 = done_cnt;
    reset = 1'b1; rsp_abort = 1;
    @(posedge clk); #1;
    check_idle_outputs("midrst");
    reset = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    check("midrst_no_done", done_cnt, d0);
    check("midrst_idle", busy, 1'b0);
    rsp_abort = 0;
    fill_rows(1);
    run_job("after_rst", 1, 0);

`ifdef NORM_SEQ_CTRL_WDOG_EN
    clear_stats();
    rsp_mute = 1;
    start = 1'b1; num_rows = 7'd2;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (norm_s_valid !== 1'b1 && cyc < 20) begin @(posedge clk); #1; cyc++; end
    check("wdog_issue_seen", cyc < 20, 1'b1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin @(posedge clk); #1; cyc++; end
    check("wdog_latency", cyc, WDOG);
    check("wdog_err_set", err, 1'b1);
    @(posedge clk); #1;
    check("wdog_busy", busy, 1'b0);
    check("wdog_sval", norm_s_valid, 1'b0);
    check("wdog_err_sticky", err, 1'b1);
    check("wdog_no_wr", wr_cnt, 0);
    rsp_mute = 0;
    fill_rows(1);
    run_job("wdog_recover", 1, 0);
`endif

    for (int k = 0; k < 4; k++) begin
      int n;
      n = $urandom_range(1, 6);
      fill_rows(n);
      run_job($sformatf("rand%0d", k), n, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
